noc_link_arbiter: RTL

- Shares one credit-flow-controlled NoC output link (enable / 16-bit data / credit) among NUM_REQ local requesters.
- Packet-locked round-robin arbitration: once granted, a requester owns the link until its last flit is accepted.
- Tracks downstream buffer credits and never issues a flit without a credit.
- Sits between the router crossbar/input queues and the link's send side.

---
 rtl/noc_link_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/noc_link_arbiter.sv
// Packet-locked round-robin arbiter for one credit-flow-controlled NoC link.
// Define NOC_ARB_STATS_EN to add the stat_flits / stat_stall counters.
module noc_link_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int CREDITS = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]      req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           out_enable,
    output logic [DATA_W-1:0]              out_data,
    input  logic                           out_credit,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy,
    output logic [$clog2(CREDITS+1)-1:0]   credit_cnt,
    output logic                           err_credit_ovf
`ifdef NOC_ARB_STATS_EN
    ,
    output logic [31:0]                    stat_flits,
    output logic [31:0]                    stat_stall
`endif
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(CREDITS+1);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam logic [GW-1:0] LAST_ID  = GW'(NUM_REQ-1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       grant_id_q, grant_id_d;
    logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]       credit_q, credit_d;
    logic                err_q, err_d;
    logic                out_enable_q, out_enable_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;

    logic                have_credit;
    logic                accept;
    logic                found;
    logic [GW-1:0]       winner;
    int                  idx;

`ifdef NOC_ARB_STATS_EN
    logic [31:0]         stat_flits_q, stat_flits_d;
    logic [31:0]         stat_stall_q, stat_stall_d;
`endif

    assign have_credit = (credit_q != '0);
    assign accept      = (state_q == BUSY) && req_valid[grant_id_q] && have_credit;

    always_comb begin
        req_ready = '0;
        if (state_q == BUSY)
            req_ready[grant_id_q] = have_credit;
    end

    // Round-robin search starting at rr_ptr; the first valid requester wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        rr_ptr_d     = rr_ptr_q;
        credit_d     = credit_q;
        err_d        = err_q;
        out_enable_d = accept;
        out_data_d   = out_data_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_id_d = winner;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (accept && req_last[grant_id_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept)
            out_data_d = req_data[int'(grant_id_q)*DATA_W +: DATA_W];

        // A credit returned while already full is lost; flag it permanently.
        if (accept && !out_credit) begin
            credit_d = credit_q - 1'b1;
        end else if (!accept && out_credit) begin
            if (credit_q == CRED_MAX)
                err_d = 1'b1;
            else
                credit_d = credit_q + 1'b1;
        end
    end

`ifdef NOC_ARB_STATS_EN
    always_comb begin
        stat_flits_d = stat_flits_q + 32'(accept);
        stat_stall_d = stat_stall_q
                     + 32'((state_q == BUSY) && req_valid[grant_id_q] && !have_credit);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            rr_ptr_q     <= '0;
            credit_q     <= CRED_MAX;
            err_q        <= 1'b0;
            out_enable_q <= 1'b0;
            out_data_q   <= '0;
`ifdef NOC_ARB_STATS_EN
            stat_flits_q <= '0;
            stat_stall_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            rr_ptr_q     <= rr_ptr_d;
            credit_q     <= credit_d;
            err_q        <= err_d;
            out_enable_q <= out_enable_d;
            out_data_q   <= out_data_d;
`ifdef NOC_ARB_STATS_EN
            stat_flits_q <= stat_flits_d;
            stat_stall_q <= stat_stall_d;
`endif
        end
    end

    assign busy           = (state_q == BUSY);
    assign grant_id       = grant_id_q;
    assign credit_cnt     = credit_q;
    assign err_credit_ovf = err_q;
    assign out_enable     = out_enable_q;
    assign out_data       = out_data_q;
`ifdef NOC_ARB_STATS_EN
    assign stat_flits     = stat_flits_q;
    assign stat_stall     = stat_stall_q;
`endif

endmodule
